// File: rtl/joy_db15_tx.sv
// joy_db15_tx: serializes two 16-button joysticks onto a DB15 host link with synchronized strobes and a shift watchdog
module joy_db15_tx #(
   parameter int TIMEOUT     = 4096,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] joystick1,
   input  logic [15:0] joystick2,
   input  logic        joy_clk,
   input  logic        joy_load,
   output logic        joy_data,
   output logic        frame_done,
   output logic        timeout_err,
   output logic [5:0]  bit_cnt
);
   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] load_sync;
   logic                   clk_prev;
   logic [31:0]            sr;
   logic [WD_W-1:0]        wd;
   logic [31:0]            frame;
   logic                   load_s;
   logic                   clk_rise;

   assign frame    = {~joystick1, ~joystick2};
   assign load_s   = load_sync[SYNC_STAGES-1];
   assign clk_rise = clk_sync[SYNC_STAGES-1] & ~clk_prev;

   // bring the host strobes into the clk domain, idling at their inactive high level
   always_ff @(posedge clk)
      if (!reset_n) begin
         clk_sync  <= '1;
         load_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], joy_clk};
         load_sync <= {load_sync[SYNC_STAGES-2:0], joy_load};
         clk_prev  <= clk_sync[SYNC_STAGES-1];
      end

   // frame FSM: capture while load is low, shift on host clock edges, abort on watchdog expiry
   always_ff @(posedge clk)
      if (!reset_n) begin
         state       <= IDLE;
         sr          <= '1;
         wd          <= '0;
         bit_cnt     <= '0;
         joy_data    <= 1'b1;
         frame_done  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         frame_done  <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               joy_data <= 1'b1;
               bit_cnt  <= '0;
               wd       <= '0;
               if (!load_s) begin
                  state    <= LOAD;
                  sr       <= frame;
                  joy_data <= frame[31];
               end
            end
            LOAD: begin
               bit_cnt <= '0;
               wd      <= '0;
               if (load_s) state <= SHIFT;
               else begin
                  sr       <= frame;
                  joy_data <= frame[31];
               end
            end
            SHIFT:
               if (!load_s) begin
                  state    <= LOAD;
                  bit_cnt  <= '0;
                  wd       <= '0;
                  sr       <= frame;
                  joy_data <= frame[31];
               end else if (clk_rise) begin
                  sr       <= {sr[30:0], 1'b1};
                  joy_data <= sr[30];
                  bit_cnt  <= bit_cnt + 6'd1;
                  wd       <= '0;
                  if (bit_cnt == 6'd31) begin
                     frame_done <= 1'b1;
                     state      <= IDLE;
                  end
               end else if (wd == WD_W'(TIMEOUT - 1)) begin
                  timeout_err <= 1'b1;
                  state       <= IDLE;
                  joy_data    <= 1'b1;
                  bit_cnt     <= '0;
                  wd          <= '0;
               end else if (wd != WD_W'(TIMEOUT)) wd <= wd + WD_W'(1);
            default: state <= IDLE;
         endcase
      end
endmodule
